jpeg_zigzag_buf: RTL and testbench

//  Ping-pong reorder buffer between quantizer and entropy coder of the JPEG encoder.

---
 rtl/jpeg_zigzag_buf.sv | 171 +++++++++++++++++
 tb/tb_jpeg_zigzag_buf.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_zigzag_buf.sv
// jpeg_zigzag_buf
//   Ping-pong reorder buffer between the quantizer and the entropy coder.
//   8x8 coefficient blocks arrive in raster order (index r*8+c) and leave in
//   JPEG zigzag order. Two 64-word banks live in a single tdpram:
//   port a is written by the input side and port b is read by the output side.
//
// Ports
//   clk         in   1    single clock for both RAM ports and all logic
//   rst         in   1    synchronous, active-high reset
//   din_valid   in   1    input coefficient valid
//   din_ready   out  1    buffer can accept (current write bank not full)
//   din         in   DW   coefficient, raster order
//   dout_valid  out  1    output coefficient valid
//   dout_ready  in   1    downstream accepts
//   dout        out  DW   coefficient, zigzag order
//   dout_last   out  1    marks the 64th coefficient of each block
//   zz_bypass   in   1    only with JPEG_ZZ_BYPASS_EN: 1 = emit raster order,
//                         sampled at the first read of each block
//
// Configuration macro: JPEG_ZZ_BYPASS_EN (adds zz_bypass port).

module tdpram #(
    parameter int AW = 7,
    parameter int DW = 12
) (
    input  logic          clka,
    input  logic          wea,
    input  logic [AW-1:0] addra,
    input  logic [DW-1:0] data_a,
    input  logic          clkb,
    input  logic          enb,
    input  logic [AW-1:0] addrb,
    output logic [DW-1:0] q_b
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clka) begin
        if (wea) mem[addra] <= data_a;
    end

    // Read data register only updates on enable, so a stalled output holds.
    always_ff @(posedge clkb) begin
        if (enb) q_b <= mem[addrb];
    end
endmodule

module jpeg_zigzag_buf #(
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          din_valid,
    output logic          din_ready,
    input  logic [DW-1:0] din,
    output logic          dout_valid,
    input  logic          dout_ready,
    output logic [DW-1:0] dout,
    output logic          dout_last
`ifdef JPEG_ZZ_BYPASS_EN
    ,
    input  logic          zz_bypass
`endif
);
    localparam logic [5:0] zz_table [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic       wr_bank;
    logic       rd_bank;
    logic [1:0] bank_full;
    logic [1:0] full_nxt;
    logic [5:0] wr_cnt;
    logic [5:0] rd_cnt;
    logic       wr_en;
    logic       rd_issue;
    logic       out_done;
    logic       use_raster;
    logic [5:0] rd_off;
    logic [6:0] wr_addr;
    logic [6:0] rd_addr;

    assign din_ready = ~bank_full[wr_bank];
    assign wr_en     = din_valid & din_ready;
    assign wr_addr   = {wr_bank, wr_cnt};

    // A read is issued whenever the current bank holds data and the output
    // register is free or being drained this cycle.
    assign rd_issue  = bank_full[rd_bank] & (~dout_valid | dout_ready);
    assign out_done  = dout_valid & dout_ready & dout_last;

`ifdef JPEG_ZZ_BYPASS_EN
    logic blk_bypass;

    // The first read of a block uses the live pin; the rest use the copy
    // captured with that first read, so the order cannot change mid-block.
    assign use_raster = (rd_cnt == 6'd0) ? zz_bypass : blk_bypass;

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_bypass <= 1'b0;
        end else if (rd_issue && rd_cnt == 6'd0) begin
            blk_bypass <= zz_bypass;
        end
    end
`else
    assign use_raster = 1'b0;
`endif

    assign rd_off  = use_raster ? rd_cnt : zz_table[rd_cnt];
    assign rd_addr = {rd_bank, rd_off};

    // rd_bank advances when the last read of a block is issued so the next
    // bank can be read back-to-back. The word still in the output register
    // therefore always belongs to ~rd_bank, which is the bank released when
    // the final word is accepted. Writer set and reader clear never collide.
    always_comb begin
        full_nxt = bank_full;
        if (out_done) full_nxt[~rd_bank] = 1'b0;
        if (wr_en && wr_cnt == 6'd63) full_nxt[wr_bank] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            bank_full  <= 2'b00;
            wr_cnt     <= 6'd0;
            rd_cnt     <= 6'd0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            bank_full <= full_nxt;

            if (wr_en) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) wr_bank <= ~wr_bank;
            end

            if (rd_issue) begin
                rd_cnt     <= rd_cnt + 6'd1;
                dout_valid <= 1'b1;
                dout_last  <= (rd_cnt == 6'd63);
                if (rd_cnt == 6'd63) rd_bank <= ~rd_bank;
            end else if (dout_ready) begin
                dout_valid <= 1'b0;
                dout_last  <= 1'b0;
            end
        end
    end

    tdpram #(
        .AW(7),
        .DW(DW)
    ) u_ram (
        .clka   (clk),
        .wea    (wr_en),
        .addra  (wr_addr),
        .data_a (din),
        .clkb   (clk),
        .enb    (rd_issue),
        .addrb  (rd_addr),
        .q_b    (dout)
    );
endmodule

// File: tb/tb_jpeg_zigzag_buf.sv
// Testbench for jpeg_zigzag_buf. Inputs are driven and outputs sampled on
// the falling edge; expected output words (data plus last flag) are queued
// when a full input block has been accepted and popped on each output transfer.
`timescale 1ns/1ps
module tb_jpeg_zigzag_buf;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          din_valid;
    logic          din_ready;
    logic [DW-1:0] din;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout;
    logic          dout_last;
`ifdef JPEG_ZZ_BYPASS_EN
    logic          zz_bypass;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [DW:0] exp_q [$];

    int   acc64_cyc;
    int   first_val_cyc;
    int   gaps;
    int   sent_at_hold;
    logic ready_at_hold;
    logic valid_at_hold;

    always #5 clk = ~clk;

    jpeg_zigzag_buf #(.DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .dout_last  (dout_last)
`ifdef JPEG_ZZ_BYPASS_EN
        ,
        .zz_bypass  (zz_bypass)
`endif
    );

    // Zigzag position k -> raster index, built by walking the anti-diagonals.
    function automatic int zz_of(input int k);
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            int lo;
            int hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    if (n == k) return r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    if (n == k) return r * 8 + (s - r);
                    n++;
                end
            end
        end
        return 0;
    endfunction

    // Drives nblk blocks and checks every output word against the queue.
    // pv/pr: percent chance of din_valid / dout_ready per cycle.
    // hold: dout_ready forced low for the first hold cycles.
    // gap_lim: count empty output cycles while 0 < words received < gap_lim.
    // flip_at: toggle zz_bypass once after this many outputs (-1 = never).
    task automatic run_stream(input int nblk, input int pv, input int pr,
                              input bit rnd, input bit zzord, input int hold,
                              input int gap_lim, input int flip_at, input int budget);
        logic [DW-1:0] blk [64];
        logic [DW-1:0] pdout;
        logic          plast;
        logic          pstall;
        logic [DW:0]   e;
        int            sent;
        int            got;
        int            cyc;
        int            total;
        bit            flipped;
        sent = 0; got = 0; cyc = 0; pstall = 1'b0; flipped = 1'b0;
        total = nblk * 64;
        pdout = '0; plast = 1'b0;
        acc64_cyc = -1; first_val_cyc = -1; gaps = 0;
        while ((sent < total || got < total) && cyc < budget) begin
            @(negedge clk);
            if (pstall) begin
                n_checks++;
                if (dout_valid !== 1'b1 || dout !== pdout || dout_last !== plast) begin
                    n_fail++;
                    $display("FAIL stall_hold cyc %0d: valid=%b dout=%0d last=%b, required valid=1 dout=%0d last=%b",
                             cyc, dout_valid, dout, dout_last, pdout, plast);
                end
            end
            if (dout_valid === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
            if (hold > 0 && cyc == hold) begin
                sent_at_hold  = sent;
                ready_at_hold = din_ready;
                valid_at_hold = dout_valid;
            end
`ifdef JPEG_ZZ_BYPASS_EN
            if (flip_at >= 0 && !flipped && got == flip_at) begin
                zz_bypass = ~zz_bypass;
                flipped = 1'b1;
            end
`endif
            din_valid  = (sent < total) && ($urandom_range(99) < pv);
            din        = rnd ? DW'($urandom) : DW'(sent);
            dout_ready = (cyc >= hold) && ($urandom_range(99) < pr);

            if (din_valid && din_ready === 1'b1) begin
                blk[sent % 64] = din;
                sent++;
                if (sent % 64 == 0) begin
                    for (int k = 0; k < 64; k++)
                        exp_q.push_back({(k == 63), blk[zzord ? zz_of(k) : k]});
                    if (sent == 64) acc64_cyc = cyc;
                end
            end

            if (dout_valid === 1'b1 && dout_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: dout=%0d last=%b, required no output", dout, dout_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({dout_last, dout} !== e) begin
                        n_fail++;
                        $display("FAIL scoreboard word %0d: dout=%0d last=%b, required dout=%0d last=%b",
                                 got, dout, dout_last, e[DW-1:0], e[DW]);
                    end
                end
                got++;
            end else if (got > 0 && got < gap_lim && dout_valid !== 1'b1) begin
                gaps++;
            end

            pstall = (dout_valid === 1'b1) && !dout_ready;
            pdout  = dout;
            plast  = dout_last;
            cyc++;
        end
        n_checks++;
        if (got != total) begin
            n_fail++;
            $display("FAIL stream_timeout: received %0d words (sent %0d), required %0d", got, sent, total);
        end
        @(negedge clk);
        din_valid  = 1'b0;
        dout_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_valid = 1'b0; dout_ready = 1'b0; din = '0;
`ifdef JPEG_ZZ_BYPASS_EN
        zz_bypass = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (din_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_din_ready: %b, required 1", din_ready);
        end
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_dout_valid: %b, required 0", dout_valid);
        end
        n_checks++;
        if (dout_last !== 1'b0) begin
            n_fail++; $display("FAIL reset_dout_last: %b, required 0", dout_last);
        end
    endtask

    task automatic test_one_block();
        exp_q.delete();
        run_stream(1, 100, 100, 1'b0, 1'b1, 0, 64, -1, 500);
        n_checks++;
        if (first_val_cyc - acc64_cyc != 2) begin
            n_fail++;
            $display("FAIL latency: first dout_valid %0d cycles after 64th input, required 2",
                     first_val_cyc - acc64_cyc);
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++; $display("FAIL one_block_gaps: %0d empty cycles, required 0", gaps);
        end
        @(negedge clk);
        n_checks++;
        if (dout_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_after_block: dout_valid=%b, required 0", dout_valid);
        end
    endtask

    task automatic test_backpressure();
        exp_q.delete();
        run_stream(3, 100, 100, 1'b0, 1'b1, 200, 128, -1, 2000);
        n_checks++;
        if (sent_at_hold != 128) begin
            n_fail++; $display("FAIL full_accept_count: %0d words accepted, required 128", sent_at_hold);
        end
        n_checks++;
        if (ready_at_hold !== 1'b0) begin
            n_fail++; $display("FAIL full_din_ready: %b, required 0", ready_at_hold);
        end
        n_checks++;
        if (valid_at_hold !== 1'b1) begin
            n_fail++; $display("FAIL full_dout_valid: %b, required 1", valid_at_hold);
        end
        n_checks++;
        if (gaps != 0) begin
            n_fail++; $display("FAIL block0_block1_gaps: %0d empty cycles, required 0", gaps);
        end
    endtask

    task automatic test_random();
        exp_q.delete();
        run_stream(20, 50, 50, 1'b1, 1'b1, 0, 0, -1, 20000);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL random_leftover: %0d words pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midblock();
        logic [DW-1:0] blk [64];
        logic [DW:0]   e;
        int            sent;
        int            got;
        int            idle_valid;
        exp_q.delete();
        sent = 0; got = 0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            if (sent == 94) begin
                din_valid = 1'b0;
                rst = 1'b1;
                break;
            end
            din_valid  = 1'b1;
            din        = DW'(sent + 100);
            dout_ready = 1'b1;
            if (din_ready === 1'b1) begin
                blk[sent % 64] = din;
                sent++;
                if (sent == 64)
                    for (int k = 0; k < 64; k++)
                        exp_q.push_back({(k == 63), blk[zz_of(k)]});
            end
            if (dout_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_checks++;
                if ({dout_last, dout} !== e) begin
                    n_fail++;
                    $display("FAIL pre_reset word %0d: dout=%0d last=%b, required dout=%0d last=%b",
                             got, dout, dout_last, e[DW-1:0], e[DW]);
                end
                got++;
            end
        end
        n_checks++;
        if (got == 0 || got >= 64) begin
            n_fail++; $display("FAIL pre_reset_progress: %0d words of block 0 read, required 1..63", got);
        end
        @(negedge clk);
        rst = 1'b0;
        dout_ready = 1'b0;
        n_checks++;
        if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dout_last !== 1'b0) begin
            n_fail++;
            $display("FAIL midblock_reset: ready=%b valid=%b last=%b, required 1 0 0",
                     din_ready, dout_valid, dout_last);
        end
        exp_q.delete();
        run_stream(1, 100, 100, 1'b0, 1'b1, 0, 64, -1, 500);
        idle_valid = 0;
        dout_ready = 1'b1;
        repeat (80) begin
            @(negedge clk);
            if (dout_valid === 1'b1) idle_valid++;
        end
        dout_ready = 1'b0;
        n_checks++;
        if (idle_valid != 0) begin
            n_fail++; $display("FAIL stale_output_after_reset: %0d valid cycles, required 0", idle_valid);
        end
    endtask

`ifdef JPEG_ZZ_BYPASS_EN
    task automatic test_bypass();
        exp_q.delete();
        zz_bypass = 1'b1;
        run_stream(1, 100, 100, 1'b0, 1'b0, 0, 64, 20, 500);
        exp_q.delete();
        zz_bypass = 1'b0;
        run_stream(1, 100, 100, 1'b0, 1'b1, 0, 64, 20, 500);
        exp_q.delete();
        zz_bypass = 1'b1;
        run_stream(2, 70, 60, 1'b1, 1'b0, 0, 0, -1, 2000);
        zz_bypass = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_one_block();
        test_backpressure();
        test_random();
        test_reset_midblock();
`ifdef JPEG_ZZ_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
